fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares one fifo write port between NUM_REQ independent requesters.
- Selects one pending requester per cycle and captures its word into a single registered output stage.
- Drives the FIFO wr_en/wr_data from that stage and honours the FIFO wr_ready backpressure.
- Sits directly in front of the fifo block; also tags each word with the winning requester index for downstream debug/routing.

Parameters:
- NUM_REQ, 4, number of requesters (>=1).
- DATA_WIDTH, 8, width of each requester word and of the FIFO write data.
- ID_WIDTH, (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1, width of the requester index.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset asserted).
- req  input  NUM_REQ  per-requester request; held high with stable data until granted.
- req_data  input  NUM_REQ*DATA_WIDTH  packed requester words; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_mask  input  NUM_REQ  per-requester enable; masked requesters are never granted.
- grant  output  NUM_REQ  one-hot accept pulse; combinational; requester i's word is consumed on the edge where grant[i]=1.
- fifo_wr_ready  input  1  FIFO can accept a write this cycle.
- fifo_wr_en  output  1  registered; output stage holds a valid word.
- fifo_wr_data  output  DATA_WIDTH  registered word to the FIFO.
- fifo_wr_id  output  ID_WIDTH  registered index of the requester that produced fifo_wr_data.

Behaviour:
- Reset (reset=0 at an edge):
  - fifo_wr_en=0, fifo_wr_data=0, fifo_wr_id=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has top priority first.
  - grant is forced to 0 while reset=0.
- Eligible set: elig = req & req_mask.
- Winner: first set bit of elig, searching from index last+1 upward with wrap-around modulo NUM_REQ.
- Stage free: stage_free = !fifo_wr_en || fifo_wr_ready.
- grant[w]=1 only if elig is nonzero and stage_free; all other grant bits are 0. At most one bit is ever set.
- On an edge with a grant:
  - fifo_wr_en<=1, fifo_wr_data<=word of w, fifo_wr_id<=w, last<=w.
- On an edge with fifo_wr_en=1, fifo_wr_ready=1 and no grant:
  - fifo_wr_en<=0; data and id hold their last values.
- On an edge with fifo_wr_en=1 and fifo_wr_ready=0:
  - Stage holds data and id unchanged, no grant is issued, and last is unchanged.
- Write handshake: the FIFO consumes the word on the edge where fifo_wr_en=1 and fifo_wr_ready=1.
  - A grant on that same edge refills the stage, so sustained throughput is 1 word/cycle.
- Latency: req high at cycle N with stage free -> grant in cycle N -> fifo_wr_en=1 with that word in cycle N+1.
- The pointer advances only on an actual grant. Backpressure, idle cycles and masked requests never change it.
- Changing req_mask takes effect the same cycle (combinational). It never affects a word already in the stage.
- A requester dropping req before being granted is legal; it simply loses its turn, with no side effects.
- Reset mid-operation: any word in the stage is discarded (fifo_wr_en=0 next cycle) and the pointer is re-initialised. Requesters must re-present their words.
- NUM_REQ=1: the block degenerates to a registered valid/ready stage; fifo_wr_id is always 0.
- No word is ever duplicated or lost between grant and the FIFO write.

Test Plan:
- Reset, then only req[2]=1, data 8'hA5, fifo_wr_ready=1 -> grant=4'b0100 in cycle 0; cycle 1: fifo_wr_en=1, fifo_wr_data=8'hA5, fifo_wr_id=2; cycle 2 (req dropped): fifo_wr_en=0.
- req=4'b1111 held, mask=4'b1111, fifo_wr_ready=1 for 8 cycles -> grant sequence 0,1,2,3,0,1,2,3, one per cycle; fifo_wr_id follows one cycle later.
- All requesters active, fifo_wr_ready=0 for 3 cycles after the first word:
  - grant=0 during the stall, fifo_wr_data/id stable.
  - On ready=1, the stalled word writes and the next grant goes to index 1 (pointer not advanced during the stall).
- req=4'b1011, req_mask=4'b1001 -> grants alternate 0,3,0,3; requesters 1 and 2 are never granted.
- Stage full with id=1, stalled; drive reset=0 for one cycle -> fifo_wr_en=0, grant=0. After release with req=4'b0110 -> first grant to index 1 (pointer back to 3).
- NUM_REQ=1 instance: req held, fifo_wr_ready toggling 1,0,1 -> exactly one FIFO write per ready-high cycle, fifo_wr_id=0, no duplicated words.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one FIFO write port
// Picks one eligible requester per cycle into a single registered stage tagged with its index.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_mask,
  output logic [NUM_REQ-1:0]              grant,
  input  logic                            fifo_wr_ready,
  output logic                            fifo_wr_en,
  output logic [DATA_WIDTH-1:0]           fifo_wr_data,
  output logic [ID_WIDTH-1:0]             fifo_wr_id
);

  localparam int SLOTS = 1 << ID_WIDTH;
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

  logic                  en_q, en_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ID_WIDTH-1:0]   last_q, last_d;

  // Padded to a power of two so the ID_WIDTH-wide winner index always selects in range.
  logic [SLOTS-1:0]      elig;
  logic [DATA_WIDTH-1:0] words [SLOTS];

  assign elig = SLOTS'(req & req_mask);

  for (genvar g = 0; g < SLOTS; g++) begin : g_words
    if (g < NUM_REQ) begin : g_live
      assign words[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_pad
      assign words[g] = '0;
    end
  end

  logic                found;
  logic [ID_WIDTH-1:0] win;
  logic [ID_WIDTH-1:0] idx;

  // Walk from last+1 with wrap so the previous winner has lowest priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = last_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx == LAST_ID) ? '0 : idx + ID_WIDTH'(1);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  logic stage_free;
  logic grant_any;

  assign stage_free = !en_q || fifo_wr_ready;
  assign grant_any  = reset && found && stage_free;

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = grant_any && (win == ID_WIDTH'(i));
    end
  end

  always_comb begin
    en_d   = en_q;
    data_d = data_q;
    id_d   = id_q;
    last_d = last_q;
    if (grant_any) begin
      en_d   = 1'b1;
      data_d = words[win];
      id_d   = win;
      last_d = win;
    end else if (fifo_wr_ready) begin
      en_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      en_q   <= 1'b0;
      data_q <= '0;
      id_q   <= '0;
      last_q <= LAST_ID;
    end else begin
      en_q   <= en_d;
      data_q <= data_d;
      id_q   <= id_d;
      last_q <= last_d;
    end
  end

  assign fifo_wr_en   = en_q;
  assign fifo_wr_data = data_q;
  assign fifo_wr_id   = id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter (4-way and 1-way instances)
module tb_fifo_wr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [3:0]  req, req_mask, grant;
  logic [31:0] req_data;
  logic        fifo_wr_ready, fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic [1:0]  fifo_wr_id;

  logic        s_req, s_mask, s_grant, s_ready, s_en;
  logic [7:0]  s_data, s_wdata;
  logic        s_id;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_mask(req_mask),
    .grant(grant), .fifo_wr_ready(fifo_wr_ready), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .fifo_wr_id(fifo_wr_id)
  );

  fifo_wr_arbiter #(.NUM_REQ(1), .DATA_WIDTH(8)) dut1 (
    .clk(clk), .reset(reset), .req(s_req), .req_data(s_data), .req_mask(s_mask),
    .grant(s_grant), .fifo_wr_ready(s_ready), .fifo_wr_en(s_en),
    .fifo_wr_data(s_wdata), .fifo_wr_id(s_id)
  );

  int total = 0;
  int bad   = 0;
  logic [9:0] sb [$];
  logic [7:0] sb1 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
    end
  endtask

  function automatic int idx_of(input logic [3:0] g);
    int r = 0;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  // Called at posedge+1; drives one cycle, checks grant at negedge, returns at next posedge+1.
  task automatic step(input logic [3:0] r, input logic [3:0] m, input logic rdy,
                      input logic [3:0] exp_g, input string name);
    int i;
    req = r; req_mask = m; fifo_wr_ready = rdy;
    @(negedge clk);
    check(name, {28'd0, grant}, {28'd0, exp_g});
    if (exp_g != 4'd0) begin
      i = idx_of(exp_g);
      sb.push_back({i[1:0], req_data[i*8 +: 8]});
    end
    @(posedge clk); #1;
  endtask

  task automatic step1(input logic r, input logic rdy, input logic exp_g, input string name);
    s_req = r; s_mask = 1'b1; s_ready = rdy;
    @(negedge clk);
    check(name, {31'd0, s_grant}, {31'd0, exp_g});
    if (exp_g) sb1.push_back(s_data);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic [3:0] r, input logic rdy);
    reset = 1'b0; req = r; req_mask = 4'hF; fifo_wr_ready = rdy;
    s_req = 1'b1; s_mask = 1'b1; s_ready = 1'b1;
    @(negedge clk);
    check("rst_grant", {28'd0, grant}, 32'd0);
    check("rst_s_grant", {31'd0, s_grant}, 32'd0);
    @(posedge clk); #1;
    check("rst_en", {31'd0, fifo_wr_en}, 32'd0);
    check("rst_data", {24'd0, fifo_wr_data}, 32'd0);
    check("rst_id", {30'd0, fifo_wr_id}, 32'd0);
    check("rst_s_en", {31'd0, s_en}, 32'd0);
    sb.delete();
    sb1.delete();
    reset = 1'b1; req = 4'd0; s_req = 1'b0;
  endtask

  logic [9:0] e4;
  always @(negedge clk) begin
    if (reset === 1'b1 && fifo_wr_en === 1'b1 && fifo_wr_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write actual id=%0d data=%0h required no write", fifo_wr_id, fifo_wr_data);
      end else begin
        e4 = sb.pop_front();
        check("wr_id", {30'd0, fifo_wr_id}, {30'd0, e4[9:8]});
        check("wr_data", {24'd0, fifo_wr_data}, {24'd0, e4[7:0]});
      end
    end
  end

  logic [7:0] e1;
  always @(negedge clk) begin
    if (reset === 1'b1 && s_en === 1'b1 && s_ready === 1'b1) begin
      if (sb1.size() == 0) begin
        total++; bad++;
        $display("FAIL s_unexpected_write actual data=%0h required no write", s_wdata);
      end else begin
        e1 = sb1.pop_front();
        check("s_wr_id", {31'd0, s_id}, 32'd0);
        check("s_wr_data", {24'd0, s_wdata}, {24'd0, e1});
      end
    end
  end

  initial begin
    reset = 1'b0; req = 4'd0; req_mask = 4'hF; req_data = 32'd0; fifo_wr_ready = 1'b1;
    s_req = 1'b0; s_mask = 1'b1; s_data = 8'd0; s_ready = 1'b1;
    @(posedge clk); #1;

    // single request, one-cycle latency
    req_data = {8'hD3, 8'hA5, 8'hB1, 8'hA0};
    do_reset(4'hF, 1'b1);
    step(4'b0100, 4'hF, 1'b1, 4'b0100, "t1_grant");
    check("t1_en", {31'd0, fifo_wr_en}, 32'd1);
    step(4'b0000, 4'hF, 1'b1, 4'b0000, "t1_idle");
    check("t1_en_drop", {31'd0, fifo_wr_en}, 32'd0);

    // full rotation with all requesting
    req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    do_reset(4'hF, 1'b1);
    for (int k = 0; k < 8; k++) step(4'hF, 4'hF, 1'b1, 4'(1 << (k % 4)), "t2_rr");
    step(4'h0, 4'hF, 1'b1, 4'h0, "t2_drain");
    check("t2_en_drop", {31'd0, fifo_wr_en}, 32'd0);

    // backpressure stall keeps stage and pointer
    do_reset(4'hF, 1'b1);
    step(4'hF, 4'hF, 1'b1, 4'b0001, "t3_first");
    for (int k = 0; k < 3; k++) begin
      step(4'hF, 4'hF, 1'b0, 4'b0000, "t3_stall_grant");
      check("t3_stall_data", {24'd0, fifo_wr_data}, 32'hA0);
      check("t3_stall_id", {30'd0, fifo_wr_id}, 32'd0);
      check("t3_stall_en", {31'd0, fifo_wr_en}, 32'd1);
    end
    step(4'hF, 4'hF, 1'b1, 4'b0010, "t3_resume");
    step(4'h0, 4'hF, 1'b1, 4'h0, "t3_drain");
    check("t3_en_drop", {31'd0, fifo_wr_en}, 32'd0);

    // masking
    do_reset(4'hF, 1'b1);
    for (int k = 0; k < 4; k++)
      step(4'b1011, 4'b1001, 1'b1, (k % 2 == 1) ? 4'b1000 : 4'b0001, "t4_mask");
    step(4'h0, 4'hF, 1'b1, 4'h0, "t4_drain");

    // reset while stalled with id 1 in stage
    do_reset(4'hF, 1'b1);
    step(4'b0010, 4'hF, 1'b1, 4'b0010, "t5_fill");
    step(4'b0000, 4'hF, 1'b0, 4'b0000, "t5_stall");
    check("t5_stall_en", {31'd0, fifo_wr_en}, 32'd1);
    check("t5_stall_id", {30'd0, fifo_wr_id}, 32'd1);
    do_reset(4'b0110, 1'b0);
    step(4'b0110, 4'hF, 1'b1, 4'b0010, "t5_after");
    step(4'h0, 4'hF, 1'b1, 4'h0, "t5_drain");
    check("t5_en_drop", {31'd0, fifo_wr_en}, 32'd0);

    // single-requester instance with ready toggling 1,0,1
    s_data = 8'h5A;
    step1(1'b1, 1'b1, 1'b1, "s_grant_a");
    s_data = 8'h5B;
    step1(1'b1, 1'b0, 1'b0, "s_stall");
    check("s_stall_data", {24'd0, s_wdata}, 32'h5A);
    step1(1'b1, 1'b1, 1'b1, "s_grant_b");
    step1(1'b0, 1'b1, 1'b0, "s_drain");
    step1(1'b0, 1'b1, 1'b0, "s_idle");
    check("s_en_drop", {31'd0, s_en}, 32'd0);

    check("sb_empty", sb.size(), 32'd0);
    check("sb1_empty", sb1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
